// File: rtl/placement_registry_pkg.sv
// Shared sizing, coordinate/entry types and FSM encodings for the placement registry.
package placement_registry_pkg;

  localparam int unsigned NEST_num       = 4;
  localparam int unsigned SUGARPATCH_num = 8;
  localparam int unsigned X_bits         = 8;
  localparam int unsigned Y_bits         = 7;
  localparam int unsigned MIN_SEP        = 16;

  localparam int unsigned NEST_num_bits       = (NEST_num > 1) ? $clog2(NEST_num) : 1;
  localparam int unsigned SUGARPATCH_num_bits = (SUGARPATCH_num > 1) ? $clog2(SUGARPATCH_num) : 1;
  localparam int unsigned ENT_num             = NEST_num + SUGARPATCH_num;
  localparam int unsigned ENT_bits            = (ENT_num > 1) ? $clog2(ENT_num) : 1;

  typedef logic [X_bits-1:0] xcoord_t;
  typedef logic [Y_bits-1:0] ycoord_t;

  typedef struct packed {
    logic    valid;
    xcoord_t x;
    ycoord_t y;
  } entry_t;

  // Query FSM encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Range check done at 32 bits so it stays meaningful whatever the id width.
  function automatic logic id_in_range(input int unsigned id, input int unsigned num);
    return id < num;
  endfunction

endpackage

// File: rtl/placement_registry_proximity_cmp.sv
// Combinational collision test of one stored entry against a query point.
module proximity_cmp
  import placement_registry_pkg::*;
(
  input  entry_t  ent,
  input  xcoord_t qx,
  input  ycoord_t qy,
  output logic    hit
);

  logic signed [X_bits:0] dx;
  logic signed [Y_bits:0] dy;
  logic        [X_bits:0] adx;
  logic        [Y_bits:0] ady;

  // One extra bit keeps the differences signed without wrap-around.
  always_comb begin
    dx  = $signed({1'b0, ent.x}) - $signed({1'b0, qx});
    dy  = $signed({1'b0, ent.y}) - $signed({1'b0, qy});
    adx = dx[X_bits] ? $unsigned(-dx) : $unsigned(dx);
    ady = dy[Y_bits] ? $unsigned(-dy) : $unsigned(dy);
    hit = ent.valid
       && (adx < (X_bits+1)'(MIN_SEP))
       && (ady < (Y_bits+1)'(MIN_SEP));
  end

endmodule

// File: rtl/placement_registry.sv
// Nest / sugar-patch coordinate store with a sequential proximity-query responder.
module placement_registry
  import placement_registry_pkg::*;
(
  input  logic                                 setup_clk,
  input  logic                                 RESET_SIM_N,
  input  logic                                 clear,
  input  logic                                 nest_we,
  input  logic [NEST_num_bits-1:0]             nest_id,
  input  logic [X_bits-1:0]                    nest_x,
  input  logic [Y_bits-1:0]                    nest_y,
  input  logic                                 patch_we,
  input  logic [SUGARPATCH_num_bits-1:0]       patch_id,
  input  logic [X_bits-1:0]                    patch_x,
  input  logic [Y_bits-1:0]                    patch_y,
  input  logic                                 qry_valid,
  input  logic [X_bits-1:0]                    qry_x,
  input  logic [Y_bits-1:0]                    qry_y,
  output logic                                 qry_ready,
  output logic                                 resp_valid,
  input  logic                                 resp_ready,
  output logic                                 resp_collision,
  output logic [ENT_bits-1:0]                  resp_hit_idx,
  output logic [NEST_num-1:0][X_bits-1:0]      nests_X,
  output logic [NEST_num-1:0][Y_bits-1:0]      nests_Y,
  output logic [ENT_num-1:0]                   valid_mask
);

  xcoord_t            ent_x [ENT_num];
  ycoord_t            ent_y [ENT_num];
  logic [ENT_num-1:0] valid_q;

  logic [1:0]          state_q;
  logic [ENT_bits-1:0] idx_q;
  xcoord_t             qx_q;
  ycoord_t             qy_q;
  logic                coll_q;
  logic [ENT_bits-1:0] hit_idx_q;

  logic [ENT_bits-1:0] nest_ent;
  logic [ENT_bits-1:0] patch_ent;
  logic                nest_wr;
  logic                patch_wr;
  entry_t              cur;
  logic                cur_hit;
  logic                last_idx;

  assign nest_ent  = ENT_bits'(nest_id);
  assign patch_ent = ENT_bits'(NEST_num) + ENT_bits'(patch_id);
  assign nest_wr   = nest_we  && id_in_range(32'(nest_id), NEST_num);
  assign patch_wr  = patch_we && id_in_range(32'(patch_id), SUGARPATCH_num);
  assign last_idx  = (idx_q == ENT_bits'(ENT_num - 1));

  // Coordinate storage; written in every state, unaffected by clear.
  always_ff @(posedge setup_clk or negedge RESET_SIM_N) begin
    if (!RESET_SIM_N) begin
      for (int unsigned i = 0; i < ENT_num; i++) begin
        ent_x[i] <= '0;
        ent_y[i] <= '0;
      end
    end else begin
      if (nest_wr) begin
        ent_x[nest_ent] <= nest_x;
        ent_y[nest_ent] <= nest_y;
      end
      if (patch_wr) begin
        ent_x[patch_ent] <= patch_x;
        ent_y[patch_ent] <= patch_y;
      end
    end
  end

  // Valid bits: writes set, clear wins over a same-cycle write.
  always_ff @(posedge setup_clk or negedge RESET_SIM_N) begin
    if (!RESET_SIM_N) begin
      valid_q <= '0;
    end else if (clear) begin
      valid_q <= '0;
    end else begin
      if (nest_wr)  valid_q[nest_ent]  <= 1'b1;
      if (patch_wr) valid_q[patch_ent] <= 1'b1;
    end
  end

  // Select the entry under scan from the current (pre-edge) storage.
  always_comb begin
    cur = '0;
    if (id_in_range(32'(idx_q), ENT_num)) begin
      cur.valid = valid_q[idx_q];
      cur.x     = ent_x[idx_q];
      cur.y     = ent_y[idx_q];
    end
  end

  proximity_cmp u_cmp (
    .ent (cur),
    .qx  (qx_q),
    .qy  (qy_q),
    .hit (cur_hit)
  );

  // Query FSM: accept in IDLE, scan one entry per cycle, hold result in RESP.
  always_ff @(posedge setup_clk or negedge RESET_SIM_N) begin
    if (!RESET_SIM_N) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      qx_q      <= '0;
      qy_q      <= '0;
      coll_q    <= 1'b0;
      hit_idx_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (qry_valid) begin
            qx_q    <= qry_x;
            qy_q    <= qry_y;
            idx_q   <= '0;
            state_q <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (cur_hit) begin
            coll_q    <= 1'b1;
            hit_idx_q <= idx_q;
            state_q   <= ST_RESP;
          end else if (last_idx) begin
            coll_q    <= 1'b0;
            hit_idx_q <= '0;
            state_q   <= ST_RESP;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        ST_RESP: begin
          if (resp_ready) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Expose nest coordinates as flat arrays.
  always_comb begin
    nests_X = '0;
    nests_Y = '0;
    for (int unsigned i = 0; i < NEST_num; i++) begin
      nests_X[i] = ent_x[i];
      nests_Y[i] = ent_y[i];
    end
  end

  assign qry_ready      = (state_q == ST_IDLE);
  assign resp_valid     = (state_q == ST_RESP);
  assign resp_collision = coll_q;
  assign resp_hit_idx   = hit_idx_q;
  assign valid_mask     = valid_q;

endmodule

// File: tb/tb_placement_registry.sv
// Self-checking bench for placement_registry: directed cases plus randomized traffic vs a behavioural model.
module tb_placement_registry;
  import placement_registry_pkg::*;

  logic                            setup_clk;
  logic                            RESET_SIM_N;
  logic                            clear;
  logic                            nest_we;
  logic [NEST_num_bits-1:0]        nest_id;
  logic [X_bits-1:0]               nest_x;
  logic [Y_bits-1:0]               nest_y;
  logic                            patch_we;
  logic [SUGARPATCH_num_bits-1:0]  patch_id;
  logic [X_bits-1:0]               patch_x;
  logic [Y_bits-1:0]               patch_y;
  logic                            qry_valid;
  logic [X_bits-1:0]               qry_x;
  logic [Y_bits-1:0]               qry_y;
  logic                            qry_ready;
  logic                            resp_valid;
  logic                            resp_ready;
  logic                            resp_collision;
  logic [ENT_bits-1:0]             resp_hit_idx;
  logic [NEST_num-1:0][X_bits-1:0] nests_X;
  logic [NEST_num-1:0][Y_bits-1:0] nests_Y;
  logic [ENT_num-1:0]              valid_mask;

  placement_registry dut (
    .setup_clk      (setup_clk),
    .RESET_SIM_N    (RESET_SIM_N),
    .clear          (clear),
    .nest_we        (nest_we),
    .nest_id        (nest_id),
    .nest_x         (nest_x),
    .nest_y         (nest_y),
    .patch_we       (patch_we),
    .patch_id       (patch_id),
    .patch_x        (patch_x),
    .patch_y        (patch_y),
    .qry_valid      (qry_valid),
    .qry_x          (qry_x),
    .qry_y          (qry_y),
    .qry_ready      (qry_ready),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_collision (resp_collision),
    .resp_hit_idx   (resp_hit_idx),
    .nests_X        (nests_X),
    .nests_Y        (nests_Y),
    .valid_mask     (valid_mask)
  );

  initial setup_clk = 1'b0;
  always #5 setup_clk = ~setup_clk;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model of the stored objects
  bit mv [ENT_num];
  int mx [ENT_num];
  int my [ENT_num];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < ENT_num; i++) begin
      mv[i] = 0; mx[i] = 0; my[i] = 0;
    end
  endfunction

  function automatic logic [ENT_num-1:0] model_mask();
    logic [ENT_num-1:0] m;
    m = '0;
    for (int i = 0; i < ENT_num; i++) m[i] = mv[i];
    return m;
  endfunction

  function automatic bit model_hit(input int k, input int qx, input int qy);
    int dx, dy;
    dx = mx[k] - qx;
    dy = my[k] - qy;
    if (dx < 0) dx = -dx;
    if (dy < 0) dy = -dy;
    return mv[k] && (dx < int'(MIN_SEP)) && (dy < int'(MIN_SEP));
  endfunction

  // One clock with optional writes/clear, called at a negedge; model follows the edge.
  task automatic cycle_wr(input bit nw, input int nid, input int nx, input int ny,
                          input bit pw, input int pid, input int px, input int py,
                          input bit clr);
    nest_we  = nw;  nest_id  = NEST_num_bits'(nid);       nest_x  = X_bits'(nx); nest_y  = Y_bits'(ny);
    patch_we = pw;  patch_id = SUGARPATCH_num_bits'(pid); patch_x = X_bits'(px); patch_y = Y_bits'(py);
    clear    = clr;
    @(posedge setup_clk);
    if (nw) begin mx[nid] = nx; my[nid] = ny; mv[nid] = 1; end
    if (pw) begin mx[NEST_num+pid] = px; my[NEST_num+pid] = py; mv[NEST_num+pid] = 1; end
    if (clr) for (int i = 0; i < ENT_num; i++) mv[i] = 0;
    @(negedge setup_clk);
    nest_we = 0; patch_we = 0; clear = 0;
  endtask

  task automatic tick();
    cycle_wr(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Full query transaction; mid_k injects nest0 + patch7 at the query point on scan cycle mid_k.
  task automatic run_query(input int qx, input int qy, input int mid_k, input bit rnd, input int hold);
    bit exp_coll, done, h;
    int exp_idx;
    bit nw, pw, clr;
    int nid, pid, nx, ny, px, py;
    chk("qry_ready_idle", qry_ready, 1);
    qry_valid = 1; qry_x = X_bits'(qx); qry_y = Y_bits'(qy);
    @(posedge setup_clk);
    @(negedge setup_clk);
    qry_valid = 0;
    exp_coll = 0; exp_idx = 0; done = 0;
    for (int k = 0; k < ENT_num && !done; k++) begin
      chk("resp_valid_scan", resp_valid, 0);
      chk("qry_ready_scan", qry_ready, 0);
      h = model_hit(k, qx, qy);
      if (h) begin exp_coll = 1; exp_idx = k; done = 1; end
      if (k == ENT_num - 1) done = 1;
      nw = 0; pw = 0; clr = 0; nid = 0; pid = 0; nx = 0; ny = 0; px = 0; py = 0;
      if (k == mid_k) begin
        nw = 1; nid = 0; nx = qx; ny = qy;
        pw = 1; pid = SUGARPATCH_num - 1; px = qx; py = qy;
      end else if (rnd && ($urandom % 3 == 0)) begin
        nw = $urandom_range(0, 1); nid = $urandom_range(0, NEST_num - 1);
        nx = $urandom_range(0, 255); ny = $urandom_range(0, 127);
        pw = $urandom_range(0, 1); pid = $urandom_range(0, SUGARPATCH_num - 1);
        px = $urandom_range(0, 255); py = $urandom_range(0, 127);
        clr = ($urandom % 8 == 0);
      end
      cycle_wr(nw, nid, nx, ny, pw, pid, px, py, clr);
    end
    chk("resp_valid", resp_valid, 1);
    chk("resp_collision", resp_collision, 32'(exp_coll));
    chk("resp_hit_idx", resp_hit_idx, 32'(exp_idx));
    chk("qry_ready_resp", qry_ready, 0);
    chk("valid_mask", valid_mask, 32'(model_mask()));
    for (int c = 0; c < hold; c++) begin
      resp_ready = 0;
      tick();
      chk("hold_resp_valid", resp_valid, 1);
      chk("hold_collision", resp_collision, 32'(exp_coll));
      chk("hold_hit_idx", resp_hit_idx, 32'(exp_idx));
      chk("hold_qry_ready", qry_ready, 0);
    end
    resp_ready = 1;
    tick();
    resp_ready = 0;
    chk("qry_ready_after", qry_ready, 1);
    chk("resp_valid_after", resp_valid, 0);
  endtask

  initial begin
    int e, qx, qy;
    RESET_SIM_N = 0;
    clear = 0; nest_we = 0; nest_id = '0; nest_x = '0; nest_y = '0;
    patch_we = 0; patch_id = '0; patch_x = '0; patch_y = '0;
    qry_valid = 0; qry_x = '0; qry_y = '0; resp_ready = 0;
    model_reset();
    #23;
    chk("rst_qry_ready", qry_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_collision", resp_collision, 0);
    chk("rst_hit_idx", resp_hit_idx, 0);
    chk("rst_valid_mask", valid_mask, 0);
    @(negedge setup_clk);
    RESET_SIM_N = 1;
    tick();
    for (int i = 0; i < NEST_num; i++) begin
      chk("rst_nests_X", nests_X[i], 0);
      chk("rst_nests_Y", nests_Y[i], 0);
    end

    // Empty registry: full scan, no hit
    run_query(50, 40, -1, 0, 0);

    // Single nest, inside and exactly on the half-box boundary
    cycle_wr(1, 2, 100, 60, 0, 0, 0, 0, 0);
    chk("nests_X2", nests_X[2], 100);
    chk("nests_Y2", nests_Y[2], 60);
    run_query(110, 70, -1, 0, 0);
    run_query(116, 60, -1, 0, 0);

    // Lowest index wins, then clear
    cycle_wr(1, 1, 12, 12, 1, 0, 10, 10, 0);
    run_query(11, 11, -1, 0, 0);
    cycle_wr(0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("clear_mask", valid_mask, 0);
    run_query(11, 11, -1, 0, 0);

    // Coordinate extremes: no wrap-around
    cycle_wr(1, 0, 0, 0, 0, 0, 0, 0, 0);
    run_query(255, 127, -1, 0, 0);
    run_query(15, 15, -1, 0, 0);

    // Same-cycle write and clear: coordinates land, valid bits do not
    cycle_wr(1, 3, 33, 44, 0, 0, 0, 0, 1);
    chk("wrclr_nests_X3", nests_X[3], 33);
    chk("wrclr_mask", valid_mask, 0);
    cycle_wr(1, 0, 0, 0, 0, 0, 0, 0, 0);

    // Mid-scan writes at idx 5: nest0 already scanned, patch7 not yet; response held 5 cycles
    run_query(80, 80, 5, 0, 5);

    // Asynchronous reset during a scan abandons the query
    qry_valid = 1; qry_x = 8'd200; qry_y = 7'd100;
    @(posedge setup_clk);
    @(negedge setup_clk);
    qry_valid = 0;
    repeat (3) @(posedge setup_clk);
    #2 RESET_SIM_N = 0;
    #1;
    chk("midrst_resp_valid", resp_valid, 0);
    chk("midrst_qry_ready", qry_ready, 1);
    chk("midrst_valid_mask", valid_mask, 0);
    chk("midrst_nests_X0", nests_X[0], 0);
    model_reset();
    @(negedge setup_clk);
    RESET_SIM_N = 1;
    tick();
    chk("postrst_resp_valid", resp_valid, 0);

    // Randomized traffic near stored points with mid-scan writes and clears
    for (int t = 0; t < 40; t++) begin
      int nwr;
      nwr = $urandom_range(0, 3);
      for (int w = 0; w < nwr; w++)
        cycle_wr($urandom_range(0, 1), $urandom_range(0, NEST_num - 1),
                 $urandom_range(0, 255), $urandom_range(0, 127),
                 $urandom_range(0, 1), $urandom_range(0, SUGARPATCH_num - 1),
                 $urandom_range(0, 255), $urandom_range(0, 127),
                 ($urandom % 10 == 0));
      e  = $urandom_range(0, ENT_num - 1);
      qx = mx[e] + $urandom_range(0, 40) - 20;
      qy = my[e] + $urandom_range(0, 40) - 20;
      if (qx < 0) qx = 0;
      if (qx > 255) qx = 255;
      if (qy < 0) qy = 0;
      if (qy > 127) qy = 127;
      run_query(qx, qy, -1, 1, $urandom_range(0, 3));
      for (int i = 0; i < NEST_num; i++) begin
        chk("rnd_nests_X", nests_X[i], 32'(mx[i]));
        chk("rnd_nests_Y", nests_Y[i], 32'(my[i]));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/placement_registry.md
Name: placement_registry

Overview:
- Responder and store for the setup-time object placer.
- Latches nest and sugar-patch centre coordinates as the placer writes them.
- Exposes the nest coordinate arrays to the ant setup and runtime logic.
- Answers proximity queries ("does (x,y) collide with any placed object?") through a valid/ready handshake, scanning stored entries sequentially at one per cycle.

Parameters:
- NEST_num, 4: nest slots.
- SUGARPATCH_num, 8: sugar-patch slots.
- X_bits, 8: x coordinate width.
- Y_bits, 7: y coordinate width.
- MIN_SEP, 16: collision half-box; a hit requires |dx|<MIN_SEP and |dy|<MIN_SEP.
- Derived: NEST_num_bits and SUGARPATCH_num_bits, each = $clog2 of the slot count (minimum 1); ENT_num = NEST_num+SUGARPATCH_num; ENT_bits = $clog2(ENT_num).

Ports:
- setup_clk  in  1  sole clock.
- RESET_SIM_N  in  1  asynchronous active-low reset.
- clear  in  1  synchronous clear of all valid bits.
- nest_we  in  1  write strobe for a nest slot.
- nest_id  in  NEST_num_bits  nest slot index.
- nest_x  in  X_bits  nest centre x.
- nest_y  in  Y_bits  nest centre y.
- patch_we  in  1  write strobe for a patch slot.
- patch_id  in  SUGARPATCH_num_bits  patch slot index.
- patch_x  in  X_bits  patch centre x.
- patch_y  in  Y_bits  patch centre y.
- qry_valid  in  1  query request.
- qry_x  in  X_bits  query x.
- qry_y  in  Y_bits  query y.
- qry_ready  out  1  high only in IDLE.
- resp_valid  out  1  response available.
- resp_ready  in  1  response consumed.
- resp_collision  out  1  1 = a valid entry lies within MIN_SEP.
- resp_hit_idx  out  ENT_bits  first hit entry (nests 0..NEST_num-1, then patches); 0 when no hit.
- nests_X  out  [NEST_num][X_bits]  stored nest x values.
- nests_Y  out  [NEST_num][Y_bits]  stored nest y values.
- valid_mask  out  ENT_num  per-entry valid bits.

Behaviour:
- Reset (RESET_SIM_N low, asynchronous):
  - Valid bits, coordinates, nests_X and nests_Y all cleared.
  - State returns to IDLE.
  - qry_ready=1, resp_valid=0, resp_collision=0, resp_hit_idx=0.
  - Reset in the middle of a scan abandons the query; no response is produced.
- Writes:
  - On an edge with nest_we=1 and nest_id<NEST_num, the slot's x/y are latched and its valid bit is set.
  - Patch writes behave the same into entries NEST_num+patch_id.
  - Out-of-range ids are ignored.
  - Rewriting a slot overwrites it.
  - nest_we and patch_we may fire in the same cycle; both take effect.
  - A write and clear in the same cycle: clear wins for the valid bits; coordinates are still written.
  - Writes are accepted in every state.
- Query FSM, states IDLE, SCAN, RESP:
  - IDLE: qry_ready=1. On qry_valid at an edge, latch qry_x/qry_y, set idx=0, go to SCAN.
  - SCAN: qry_ready=0. Each cycle compare entry idx against the latched query.
    - dx and dy are computed as signed (X_bits+1)-bit and (Y_bits+1)-bit differences; no wrap-around.
    - Hit = valid[idx] && |dx|<MIN_SEP && |dy|<MIN_SEP.
    - On a hit, or when idx==ENT_num-1, latch the result and go to RESP. Otherwise idx++.
    - The first hit terminates the scan (lowest index wins).
  - RESP: resp_valid=1 and results held stable. On resp_ready at an edge, go to IDLE.
    - qry_ready stays 0 until the cycle after the handshake; there is no back-to-back acceptance in the same edge.
- Latency:
  - If the query is accepted at edge E0 and entry k hits, resp_valid is high after edge E0+k+1.
  - With no hit, resp_valid is high after edge E0+ENT_num.
- Write/scan interaction:
  - An entry's state is sampled in the cycle it is compared.
  - A write to an entry already scanned does not affect the current response.
  - A write to an entry not yet scanned does affect it.
- clear during SCAN: entries compared after the clear see valid=0.

Decomposition:
- Shared package (params.sv): X_bits, Y_bits, NEST_num, SUGARPATCH_num, the *_num_bits values, MIN_SEP, and typedefs xcoord_t, ycoord_t and entry_t {valid, x, y}.
- One sub-module is natural: proximity_cmp, purely combinational. It takes the entry and the query point and outputs hit.
- The FSM, idx counter and storage stay in the top module.

Test Plan:
- Reset, then query (50,40) with no writes → resp_valid after 12 edges (ENT_num=12), resp_collision=0, resp_hit_idx=0; nests_X all 0.
- Write nest 2 at (100,60), then query (110,70) → collision=1, hit_idx=2, resp_valid after edge E0+3. Query (116,60) → collision=0, because |dx|=16 is not less than MIN_SEP.
- Write patch 0 at (10,10) and nest 1 at (12,12), then query (11,11) → hit_idx=1 (lowest index wins). Pulse clear, repeat the query → collision=0.
- Coordinate edges: write nest 0 at (0,0), query (255,127) → no hit, confirming no wrap-around. Query (15,15) → hit.
- Mid-scan writes: query (80,80); on the cycle idx=5, write patch 7 (entry 11) at (80,80) and nest 0 at (80,80) → collision=1, hit_idx=11.
- Hold resp_ready=0 for 5 cycles → response stable and qry_ready=0 throughout. Then assert RESET_SIM_N=0 during a later SCAN → resp_valid=0, qry_ready=1, valid_mask=0 immediately.
